// File: rtl/findmax_pkg.sv
// Shared types and widths for the findmax job arbiter slice.
package findmax_pkg;

    localparam int ADDR_W = 16;
    localparam int N_W    = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] start_addr;
        logic [N_W-1:0]    n;
    } job_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/findmax_job_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the
// previous winner and wraps, so the last winner has lowest priority.
module rr_arbiter
    import findmax_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Walk the requesters in rotated priority order and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/findmax_job_arbiter.sv
// Shares one max-finding datapath between NUM_REQ requesters: picks a job
// round-robin, runs the datapath until it reports done, then hands the
// max word back to the winner. One job is in flight at a time.
// Optional feature macro: FINDMAX_TIMEOUT_EN adds a BUSY-cycle watchdog
// that returns rsp_err=1 / rsp_max=16'hFFFF after TIMEOUT_CYCLES cycles.
module findmax_job_arbiter
    import findmax_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [ADDR_W*NUM_REQ-1:0] req_start_addr,
    input  logic [N_W*NUM_REQ-1:0]    req_n,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_max,
    output logic                      rsp_err,
    output logic                      dp_active,
    output logic [ADDR_W-1:0]         dp_start_addr,
    output logic [N_W-1:0]            dp_n,
    input  logic                      dp_done,
    input  logic [DATA_W-1:0]         dp_max
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_any;
    job_t               sel_job;

`ifdef FINDMAX_TIMEOUT_EN
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] busy_cnt;
    logic             rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // Only IDLE offers a slot; the arbiter's one-hot winner is the ready.
    assign req_ready = (state == IDLE) ? arb_grant : '0;

    // Pull the winning requester's job fields out of the packed buses.
    always_comb begin
        sel_job = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_job.start_addr = req_start_addr[i*ADDR_W +: ADDR_W];
                sel_job.n          = req_n[i*N_W +: N_W];
            end
        end
    end

    // Job sequencer: accept, run the datapath (or skip it for N=0), respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            dp_active     <= 1'b0;
            dp_start_addr <= '0;
            dp_n          <= '0;
            rsp_valid     <= '0;
            rsp_max       <= '0;
            grant_q       <= '0;
            last_grant    <= IDX_W'(NUM_REQ - 1);
`ifdef FINDMAX_TIMEOUT_EN
            busy_cnt      <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        dp_start_addr <= sel_job.start_addr;
                        dp_n          <= sel_job.n;
                        grant_q       <= arb_idx;
                        if (sel_job.n != '0) begin
                            dp_active <= 1'b1;
                            state     <= BUSY;
`ifdef FINDMAX_TIMEOUT_EN
                            busy_cnt  <= '0;
`endif
                        end else begin
                            rsp_max   <= '0;
                            rsp_valid <= arb_grant;
`ifdef FINDMAX_TIMEOUT_EN
                            rsp_err_q <= 1'b0;
`endif
                            state     <= RESPOND;
                        end
                    end
                end
                BUSY: begin
                    if (dp_done) begin
                        rsp_max   <= dp_max;
                        dp_active <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << grant_q;
`ifdef FINDMAX_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= RESPOND;
                    end
`ifdef FINDMAX_TIMEOUT_EN
                    else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_max   <= '1;
                        rsp_err_q <= 1'b1;
                        dp_active <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << grant_q;
                        state     <= RESPOND;
                    end else begin
                        busy_cnt  <= busy_cnt + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid  <= '0;
                        last_grant <= grant_q;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
